// File: rtl/alu_cmd_issuer_pkg.sv
// rtl/alu_cmd_issuer_pkg.sv - shared widths, op encodings and command/response records
package alu_cmd_issuer_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;
  localparam int TAG_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              c;
    logic [TAG_W-1:0]  tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and response channels of the issuer
interface alu_cmd_issuer_if;
  import alu_cmd_issuer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_out;
  logic              rsp_c;
  logic [TAG_W-1:0]  rsp_tag;

  // master is the issuer itself; slave is the command source, ALU and response sink
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_c,
    output rsp_valid, rsp_out, rsp_c, rsp_tag,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_c,
    input  rsp_valid, rsp_out, rsp_c, rsp_tag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_sync_fifo.sv
// rtl/alu_sync_fifo.sv - synchronous FIFO with wrap-bit pointers
module alu_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  // a pop frees the head slot in the same edge, so a full FIFO may still take a push
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;
  // stale entries stay hidden after a flush
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers tagged commands, issues them to the ALU, returns results
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter  int CMD_DEPTH = 4,
  parameter  int RSP_DEPTH = 4,
  parameter  int ALU_LAT   = 1,
  localparam int INF_W     = $clog2(ALU_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issuer_if.master bus,
  output logic [INF_W-1:0] inflight,
  output logic             busy
);

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W  = ((RSP_CW > INF_W) ? RSP_CW : INF_W) + 1;

  alu_cmd_t          cmd_din, cmd_dout;
  alu_rsp_t          rsp_din, rsp_dout;
  logic              cmd_push, cmd_full, cmd_empty;
  logic              rsp_pop, rsp_full, rsp_empty;
  logic [CMD_CW-1:0] cmd_count;
  logic [RSP_CW-1:0] rsp_count;
  logic [SUM_W-1:0]  credits_used;
  logic              issue, capture;

  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  alu_op_e           alu_op_q;
  logic [ALU_LAT:0]  vld_sr_q, vld_sr_d;
  logic [TAG_W-1:0]  tag_sr_q [ALU_LAT+1];
  logic [INF_W-1:0]  inflight_q, inflight_d;

  assign cmd_push = bus.cmd_valid && !cmd_full;
  assign cmd_din  = '{a: bus.cmd_a, b: bus.cmd_b, op: alu_op_e'(bus.cmd_op), tag: bus.cmd_tag};

  alu_sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .pop   (issue),
    .din   (cmd_din),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // every slot already holding or owed a result counts against the response FIFO
  assign credits_used = SUM_W'(rsp_count) + SUM_W'(inflight_q);
  assign issue        = !cmd_empty && (credits_used < SUM_W'(RSP_DEPTH));
  assign capture      = vld_sr_q[ALU_LAT];

  always_comb begin
    vld_sr_d   = {vld_sr_q[ALU_LAT-1:0], issue};
    inflight_d = inflight_q;
    unique case ({issue, capture})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= OP_ADD;
      vld_sr_q   <= '0;
      inflight_q <= '0;
      for (int i = 0; i <= ALU_LAT; i++) tag_sr_q[i] <= '0;
    end else begin
      if (issue) begin
        alu_a_q  <= cmd_dout.a;
        alu_b_q  <= cmd_dout.b;
        alu_op_q <= cmd_dout.op;
      end
      vld_sr_q    <= vld_sr_d;
      inflight_q  <= inflight_d;
      // tags ride alongside the valid bits; only slots with a valid bit are ever used
      tag_sr_q[0] <= cmd_dout.tag;
      for (int i = 1; i <= ALU_LAT; i++) tag_sr_q[i] <= tag_sr_q[i-1];
    end
  end

  assign rsp_din = '{out: bus.alu_out, c: bus.alu_c, tag: tag_sr_q[ALU_LAT]};
  assign rsp_pop = !rsp_empty && bus.rsp_ready;

  alu_sync_fifo #(.WIDTH($bits(alu_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (rsp_pop),
    .din   (rsp_din),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(capture && rsp_full));

  assign bus.cmd_ready = !cmd_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = !rsp_empty;
  assign bus.rsp_out   = rsp_dout.out;
  assign bus.rsp_c     = rsp_dout.c;
  assign bus.rsp_tag   = rsp_dout.tag;
  assign inflight      = inflight_q;
  assign busy          = (cmd_count != '0) || !rsp_empty || (inflight_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] inflight;
  logic       busy;

  alu_cmd_issuer_if bus ();

  alu_cmd_issuer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .inflight (inflight),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cycles[$];
  int   tests = 0, fails = 0, cyc = 0, rsp_cnt = 0;
  logic acc, got;

  task automatic chk(input string name, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s", name);
    end
  endtask

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  always @(posedge clk) {bus.alu_c, bus.alu_out} <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic cycle();
    exp_t e;
    #1;
    acc = bus.cmd_valid && bus.cmd_ready;
    if (acc) begin
      {e.c, e.out} = alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op);
      e.tag = bus.cmd_tag;
      exp_q.push_back(e);
    end
    got = bus.rsp_valid && bus.rsp_ready;
    if (got) begin
      chk("rsp_expected", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_out", bus.rsp_out === e.out);
        chk("rsp_c", bus.rsp_c === e.c);
        chk("rsp_tag", bus.rsp_tag === e.tag);
      end
      rsp_cnt++;
      rsp_cycles.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic [3:0] tag);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag; bus.cmd_valid = 1'b1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic [3:0] tag);
    int n = 0;
    drive(a, b, op, tag);
    do begin cycle(); n++; end while (!acc && n < 50);
    bus.cmd_valid = 1'b0;
    chk("send_accept", acc === 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin cycle(); n++; end
    chk("drain_done", exp_q.size() == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, r0, acc_n, sent;
    logic [7:0] t4_a [10];
    logic [7:0] t4_b [10];
    logic [1:0] t4_op[10];

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready === 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid === 1'b0);
    chk("rst_alu_a", bus.alu_a === 8'h00);
    chk("rst_alu_op", bus.alu_op === 2'd0);
    chk("rst_rsp_out", bus.rsp_out === 8'h00);
    chk("rst_inflight", inflight === 2'd0);
    chk("rst_busy", busy === 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive(8'h0F, 8'h01, 2'd0, 4'd3);
    bus.rsp_ready = 1'b1;
    cycle();
    bus.cmd_valid = 1'b0;
    chk("t2_accept", acc === 1'b1);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (lat == 1) chk("t2_busy", busy === 1'b1);
      if (lat == 2) begin
        chk("t2_inflight", inflight === 2'd1);
        chk("t2_alu_a", bus.alu_a === 8'h0F);
      end
      cycle();
      lat++;
    end
    chk("t2_latency", lat == 4);
    chk("t2_rsp_out", bus.rsp_out === 8'h10);
    chk("t2_rsp_c", bus.rsp_c === 1'b0);
    chk("t2_rsp_tag", bus.rsp_tag === 4'd3);
    cycle();
    chk("t2_rsp_valid_low", bus.rsp_valid === 1'b0);
    chk("t2_idle_busy", busy === 1'b0);
    chk("t2_idle_inflight", inflight === 2'd0);

    rsp_cycles.delete();
    for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 2'($urandom), 4'(i));
    drain();
    chk("t3_rsp_count", rsp_cycles.size() == 8);
    if (rsp_cycles.size() == 8) chk("t3_no_gaps", (rsp_cycles[7] - rsp_cycles[0]) == 7);

    for (int i = 0; i < 10; i++) begin
      t4_a[i] = 8'($urandom); t4_b[i] = 8'($urandom); t4_op[i] = 2'($urandom);
    end
    bus.rsp_ready = 1'b0;
    acc_n = 0;
    r0 = rsp_cnt;
    for (int c = 0; c < 20; c++) begin
      drive(t4_a[acc_n], t4_b[acc_n], t4_op[acc_n], 4'(acc_n));
      cycle();
      if (acc) acc_n++;
    end
    chk("t4_accepted", acc_n == 8);
    chk("t4_cmd_ready", bus.cmd_ready === 1'b0);
    chk("t4_inflight", inflight === 2'd0);
    chk("t4_rsp_valid", bus.rsp_valid === 1'b1);
    chk("t4_head_tag", bus.rsp_tag === 4'd0);
    chk("t4_last_issued_a", bus.alu_a === t4_a[3]);
    chk("t4_last_issued_b", bus.alu_b === t4_b[3]);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 50 && acc_n < 10; c++) begin
      drive(t4_a[acc_n], t4_b[acc_n], t4_op[acc_n], 4'(acc_n));
      cycle();
      if (acc) acc_n++;
    end
    bus.cmd_valid = 1'b0;
    drain();
    chk("t4_all_returned", (rsp_cnt - r0) == 10);

    bus.rsp_ready = 1'b0;
    send(8'hFF, 8'h01, 2'd0, 4'd5);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin cycle(); lat++; end
    chk("t5_rsp_valid", bus.rsp_valid === 1'b1);
    chk("t5_rsp_out", bus.rsp_out === 8'h00);
    chk("t5_rsp_c", bus.rsp_c === 1'b1);
    drain();

    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 2'($urandom), 4'(10 + i));
    repeat (6) cycle();
    for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 2'($urandom), 4'(13 + i));
    chk("t6_busy_before", busy === 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", bus.rsp_valid === 1'b0);
    chk("t6_busy", busy === 1'b0);
    chk("t6_inflight", inflight === 2'd0);
    chk("t6_cmd_ready", bus.cmd_ready === 1'b1);
    chk("t6_alu_a", bus.alu_a === 8'h00);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    r0 = rsp_cnt;
    send(8'($urandom), 8'($urandom), 2'($urandom), 4'd9);
    repeat (12) cycle();
    chk("t6_single_rsp", (rsp_cnt - r0) == 1);
    chk("t6_scoreboard_empty", exp_q.size() == 0);

    sent = 0;
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < 3000 && (sent < 40 || exp_q.size() != 0); n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40 && !bus.cmd_valid && $urandom_range(0, 2) != 0)
        drive(8'($urandom), 8'($urandom), 2'($urandom), 4'(sent));
      cycle();
      if (acc) begin sent++; bus.cmd_valid = 1'b0; end
      chk("soak_inflight_bound", inflight <= 2'd2);
    end
    chk("soak_sent", sent == 40);
    chk("soak_scoreboard_empty", exp_q.size() == 0);
    bus.rsp_ready = 1'b1;
    repeat (2) cycle();
    chk("soak_idle", busy === 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
